// File: rtl/int_mult_seq.sv
// int_mult_seq: operand front-end and result retirement stage wrapped around
// the pipelined int_mult tree multiplier. Requests are converted to unsigned
// magnitudes, tracked through the fixed multiplier latency, sign-restored on
// retirement and buffered in a credit-protected output FIFO so downstream
// backpressure never stalls the free-running multiplier.
module int_mult_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int MULT_LAT   = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_signed,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    mult_en,
    output logic [DATA_WIDTH-1:0]   mult_cand,
    output logic [DATA_WIDTH-1:0]   mult_plier,
    input  logic [2*DATA_WIDTH-1:0] mult_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Credit counter: ops in the multiplier plus ops sitting in the FIFO.
    logic [CW-1:0] occ;

    logic accept;
    logic pop;
    logic push;

    logic [DATA_WIDTH-1:0] mag_a;
    logic [DATA_WIDTH-1:0] mag_b;
    logic                  neg_in;

    logic [MULT_LAT:0] trk_valid;
    logic [MULT_LAT:0] trk_neg;
    logic [TAG_W-1:0]  trk_tag [MULT_LAT+1];

    logic [PW-1:0] retire_result;

    logic [PW-1:0]    mem_result [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag    [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Handshake decode; a pop only frees a credit from the next cycle on
    // because in_ready looks at the registered occ.
    always_comb begin
        in_ready = !rst && (occ < CW'(FIFO_DEPTH));
        mult_en  = !rst;
        accept   = in_valid && in_ready;
        out_valid = (count != '0);
        pop      = out_valid && out_ready;
        push     = trk_valid[MULT_LAT];
    end

    // Signed operands become magnitudes; the most-negative value maps to
    // 2^(W-1), which is exact as an unsigned W-bit number.
    always_comb begin
        mag_a  = in_a;
        mag_b  = in_b;
        neg_in = 1'b0;
        if (in_signed) begin
            if (in_a[DATA_WIDTH-1]) mag_a = -in_a;
            if (in_b[DATA_WIDTH-1]) mag_b = -in_b;
            neg_in = in_a[DATA_WIDTH-1] ^ in_b[DATA_WIDTH-1];
        end
    end

    // Operand registers feed the multiplier and change only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_cand  <= '0;
            mult_plier <= '0;
        end else if (accept) begin
            mult_cand  <= mag_a;
            mult_plier <= mag_b;
        end
    end

    // Credit counter: accept takes a credit, pop returns one.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Tracking tokens shadow each op through the multiplier latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_neg   <= '0;
            for (int i = 0; i <= MULT_LAT; i++) trk_tag[i] <= '0;
        end else begin
            trk_valid <= {trk_valid[MULT_LAT-1:0], accept};
            trk_neg   <= {trk_neg[MULT_LAT-1:0], neg_in};
            trk_tag[0] <= in_tag;
            for (int i = 1; i <= MULT_LAT; i++) trk_tag[i] <= trk_tag[i-1];
        end
    end

    // Sign restoration of the retiring product (wraps within 2*DATA_WIDTH).
    always_comb begin
        retire_result = trk_neg[MULT_LAT] ? -mult_result : mult_result;
    end

    // Output FIFO; credits guarantee a push never lands on a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_tag[i]    <= '0;
            end
        end else begin
            if (push) begin
                mem_result[wr_ptr] <= retire_result;
                mem_tag[wr_ptr]    <= trk_tag[MULT_LAT];
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO is presented directly and stays put until popped.
    always_comb begin
        out_result = mem_result[rd_ptr];
        out_tag    = mem_tag[rd_ptr];
    end

endmodule

// File: tb/tb_int_mult_seq.sv
// tb_int_mult_seq: directed self-checking bench for int_mult_seq with a
// behavioural MULT_LAT-deep multiplier pipeline standing in for int_mult.
module tb_int_mult_seq;

    localparam int W     = 32;
    localparam int LAT   = 5;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          mult_en;
    logic [W-1:0]  mult_cand;
    logic [W-1:0]  mult_plier;
    logic [2*W-1:0] mult_result;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*W-1:0] out_result;
    logic [TW-1:0] out_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int overflow_cnt = 0;

    int_mult_seq #(
        .DATA_WIDTH(W),
        .MULT_LAT(LAT),
        .FIFO_DEPTH(DEPTH),
        .TAG_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_signed(in_signed),
        .in_tag(in_tag),
        .in_a(in_a),
        .in_b(in_b),
        .mult_en(mult_en),
        .mult_cand(mult_cand),
        .mult_plier(mult_plier),
        .mult_result(mult_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Free-running multiplier model: product appears LAT edges after operands.
    logic [2*W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mult_en ? ({32'b0, mult_cand} * {32'b0, mult_plier}) : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mult_result = pipe[LAT-1];

    // Watch for a retirement landing on a full FIFO.
    always @(posedge clk) begin
        if (!rst && dut.push && (int'(dut.count) == DEPTH)) overflow_cnt++;
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (mult_en !== 1'b0) begin n_fail++; $display("FAIL reset_mult_en got %b want 0", mult_en); end
        n_checks++; if (mult_cand !== '0 || mult_plier !== '0) begin n_fail++; $display("FAIL reset_operands got %h/%h want 0/0", mult_cand, mult_plier); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_result !== '0 || out_tag !== '0) begin n_fail++; $display("FAIL reset_out_data got %h/%h want 0/0", out_result, out_tag); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
        n_checks++; if (mult_en !== 1'b1) begin n_fail++; $display("FAIL release_mult_en got %b want 1", mult_en); end
    endtask

    task automatic test_single_unsigned;
        int lat = 0;
        logic [2*W-1:0] res = '0;
        logic [TW-1:0] tg = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_signed = 1'b0; in_a = 3; in_b = 5; in_tag = 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (mult_cand !== 32'd3 || mult_plier !== 32'd5) begin n_fail++; $display("FAIL single_operands got %0d/%0d want 3/5", mult_cand, mult_plier); end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin lat = i; res = out_result; tg = out_tag; break; end
        end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL single_latency got %0d want 6", lat); end
        n_checks++; if (res !== 64'd15) begin n_fail++; $display("FAIL single_result got %0d want 15", res); end
        n_checks++; if (tg !== 4'd1) begin n_fail++; $display("FAIL single_tag got %0d want 1", tg); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_signed_corners;
        logic [W-1:0]   ta [7] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0]   tb [7] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd1};
        logic           ts [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2*W-1:0] te [7] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001,
                                   64'd1, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000};
        logic [W-1:0]   tma [7] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0]   tmb [7] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd2, 32'd1};
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            int lat = 0;
            logic [2*W-1:0] res = '0;
            logic [TW-1:0] tg = '0;
            in_valid = 1'b1; in_signed = ts[k]; in_a = ta[k]; in_b = tb[k]; in_tag = 4'(k + 2);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++; if (mult_cand !== tma[k] || mult_plier !== tmb[k]) begin n_fail++; $display("FAIL corner%0d_magnitude got %h/%h want %h/%h", k, mult_cand, mult_plier, tma[k], tmb[k]); end
            for (int i = 1; i <= 12; i++) begin
                @(posedge clk); #1;
                if (out_valid === 1'b1) begin lat = i; res = out_result; tg = out_tag; break; end
            end
            n_checks++; if (lat != 6) begin n_fail++; $display("FAIL corner%0d_latency got %0d want 6", k, lat); end
            n_checks++; if (res !== te[k]) begin n_fail++; $display("FAIL corner%0d_result got %h want %h", k, res, te[k]); end
            n_checks++; if (tg !== 4'(k + 2)) begin n_fail++; $display("FAIL corner%0d_tag got %0d want %0d", k, tg, k + 2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int k = 0;
        logic acc_now;
        out_ready = 1'b0;
        in_signed = 1'b0;
        in_valid = 1'b1; in_a = 1; in_b = 2; in_tag = 4'd8;
        for (int c = 0; c < 12; c++) begin
            acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                k++;
                in_a = 32'(k + 1); in_b = 32'(k + 2); in_tag = 4'(8 + k);
            end
        end
        in_valid = 1'b0;
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_accepts got %0d want 4", k); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same_cycle got %b want 0", in_ready); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got %b want 1", j, out_valid); end
            n_checks++; if (out_tag !== 4'(8 + j)) begin n_fail++; $display("FAIL bp_tag%0d got %0d want %0d", j, out_tag, 8 + j); end
            n_checks++; if (out_result !== 64'((j + 1) * (j + 2))) begin n_fail++; $display("FAIL bp_result%0d got %0d want %0d", j, out_result, (j + 1) * (j + 2)); end
            @(posedge clk); #1;
            if (j == 0) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_streaming;
        logic [2*W-1:0] q_res [$];
        logic [TW-1:0]  q_tag [$];
        int issued = 0;
        int received = 0;
        int outstanding = 0;
        int max_out = 0;
        int ready_errs = 0;
        logic acc;
        logic pp;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom_range(0, 1)); in_tag = 4'(issued);
        for (int c = 0; c < 400 && received < 20; c++) begin
            if (in_ready !== 1'(outstanding < DEPTH)) ready_errs++;
            acc = in_valid && in_ready;
            pp  = out_valid;
            if (pp) begin
                if (q_res.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL stream_unexpected_result got tag %0d want none", out_tag);
                end else begin
                    n_checks++; if (out_result !== q_res[0]) begin n_fail++; $display("FAIL stream_result%0d got %h want %h", received, out_result, q_res[0]); end
                    n_checks++; if (out_tag !== q_tag[0]) begin n_fail++; $display("FAIL stream_tag%0d got %0d want %0d", received, out_tag, q_tag[0]); end
                    void'(q_res.pop_front());
                    void'(q_tag.pop_front());
                end
                received++;
            end
            if (acc) begin
                if (in_signed)
                    q_res.push_back(64'(longint'($signed(in_a)) * longint'($signed(in_b))));
                else
                    q_res.push_back({32'b0, in_a} * {32'b0, in_b});
                q_tag.push_back(in_tag);
            end
            @(posedge clk); #1;
            outstanding = outstanding + int'(acc) - int'(pp);
            if (outstanding > max_out) max_out = outstanding;
            if (acc) begin
                issued++;
                if (issued < 20) begin
                    in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom_range(0, 1)); in_tag = 4'(issued);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_checks++; if (received != 20) begin n_fail++; $display("FAIL stream_count got %0d want 20", received); end
        n_checks++; if (ready_errs != 0) begin n_fail++; $display("FAIL stream_in_ready got %0d wrong cycles want 0", ready_errs); end
        n_checks++; if (max_out > DEPTH) begin n_fail++; $display("FAIL stream_occ got %0d want <= %0d", max_out, DEPTH); end
        n_checks++; if (overflow_cnt != 0) begin n_fail++; $display("FAIL stream_overflow got %0d want 0", overflow_cnt); end
    endtask

    task automatic test_reset_midflight;
        int lat = 0;
        int seen = 0;
        logic [2*W-1:0] res = '0;
        logic [TW-1:0] tg = '0;
        out_ready = 1'b1;
        in_signed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 32'(k + 2); in_b = 32'd3; in_tag = 4'(k + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready_in_reset got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready_release got %b want 1", in_ready); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_discard got %0d valid cycles want 0", seen); end
        in_valid = 1'b1; in_signed = 1'b1; in_a = 32'hFFFF_FFFE; in_b = 32'd3; in_tag = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin lat = i; res = out_result; tg = out_tag; break; end
        end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL mid_new_latency got %0d want 6", lat); end
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mid_new_result got %h want fffffffffffffffa", res); end
        n_checks++; if (tg !== 4'd5) begin n_fail++; $display("FAIL mid_new_tag got %0d want 5", tg); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_single_unsigned;
        test_signed_corners;
        test_backpressure;
        test_streaming;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
